uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

FIFO controller that turns a single-port, registered-read BRAM into a valid/ready byte queue between the UART receiver and the CPU-side UART register interface. It owns the read and write pointers, the occupancy count and the port arbitration, and drives the BRAM's address, write-data and write-enable. It also presents one registered output entry to the consumer.

## Interface
- ADDR_WIDTH, 9, BRAM address width; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, byte width.
- Clock and reset: one clock, `clk`. Reset is `rst_n`, asynchronous and active-low.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_WIDTH  byte from the UART receiver.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  controller can accept a write.
- out_data  out  DATA_WIDTH  registered head byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes out_data this cycle.
- flush  in  1  synchronous empty of the whole queue.
- clr_overflow  in  1  clears the overflow flag.
- overflow  out  1  sticky flag for a dropped write.
- level  out  ADDR_WIDTH+1  total bytes held.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_wd  out  DATA_WIDTH  BRAM write data; equals in_data.
- mem_wen  out  1  BRAM write enable.
- mem_rd  in  DATA_WIDTH  BRAM read data; valid one cycle after the address is presented.

## Operation
- **State registers:**
  - wptr, rptr: ADDR_WIDTH wide; wrap modulo DEPTH with no special case.
  - mem_count: 0..DEPTH, ADDR_WIDTH+1 bits.
  - rd_pending: 1 bit.
  - out_valid, out_data.
  - overflow.
- **Write accept:** `wr = in_valid && in_ready`, with `in_ready = (mem_count != DEPTH)`.
  - On wr: mem_wen=1, mem_addr=wptr, wptr+1, mem_count+1.
  - Writes take priority because the UART receiver cannot stall.
- **Read issue:** `rd_issue = (mem_count != 0) && !rd_pending && (!out_valid || out_ready) && !wr`.
  - On rd_issue: mem_addr=rptr, mem_wen=0, rptr+1, mem_count-1, rd_pending set next cycle.
- **Single port:** wr and rd_issue are mutually exclusive by construction, so mem_count never increments and decrements in the same cycle.
- **Idle address:** when neither wr nor rd_issue, mem_addr=rptr and mem_wen=0.
- **Capture:** when rd_pending=1, out_data <= mem_rd, out_valid <= 1, rd_pending <= 0.
  - rd_pending and out_valid are never both 1.
- **Pop:** `out_valid && out_ready` with no capture this cycle clears out_valid. A pop is allowed in the same cycle as a read issue.
- **Overflow:** `in_valid && !in_ready` sets overflow. The dropped byte is not written and no state changes.
  - clr_overflow clears overflow.
  - If a set and clr_overflow occur in the same cycle, set wins.
- **level:** `mem_count + rd_pending + out_valid`; maximum DEPTH+1, fits in ADDR_WIDTH+1 bits.
- **flush:** next cycle wptr=rptr=0, mem_count=0, rd_pending=0, out_valid=0.
  - A pending read is discarded.
  - A write in the flush cycle is suppressed: mem_wen=0.
  - overflow is unaffected.
- **Reset values:**
  - All pointers and counts 0; rd_pending 0.
  - out_valid 0, out_data 0, overflow 0, level 0.
  - in_ready 1, mem_wen 0, mem_addr 0.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). Stored BRAM contents are abandoned.

## Timing
- Empty-queue latency: write accepted in cycle 0, read issued in cycle 1, capture in cycle 2, out_valid=1 in cycle 3.
- Sustained drain, no writes, out_ready=1: one byte per 2 cycles (issue, capture).
- Each accepted write delays the next read issue by one cycle.
- in_ready depends only on registered mem_count; no combinational path from out_ready.
- out_data and out_valid are registered. mem_addr and mem_wen are combinational from registered state plus in_valid.

## Structure
- Package uart_pkg: DATA_WIDTH/ADDR_WIDTH defaults and DEPTH derived as 1 << ADDR_WIDTH.
- No sub-module inside the controller. The single-port BRAM is instantiated beside it at the UART top level and wired through the mem_* ports.

## Test plan
- **Reset, then a single write of 0xA5:** in_ready=1 throughout; mem_wen pulses at address 0; out_valid rises 3 cycles later with out_data=0xA5; level goes 1→1→1; pop → level=0.
- **Burst of 4 writes 0x01..0x04 back-to-back, then out_ready=1:** bytes out in order 0x01..0x04; no read issued during write cycles; rptr and wptr both 4 at the end.
- **Fill with DEPTH writes, out_ready=0:**
  - The first byte moves to the output register, so level=DEPTH and in_ready=1.
  - One more write brings level to DEPTH+1=513 and in_ready=0.
  - A further write with in_valid=1 sets overflow and leaves level at 513.
  - clr_overflow clears the flag.
- **Wrap-around:** run 600 write/read pairs with interleaved timing; output sequence matches input with no loss; pointers wrap 511→0.
- **flush with rd_pending=1 and 3 bytes queued:** next cycle level=0 and out_valid=0; the discarded pending data never appears; a subsequent write of 0x5A appears after 3 cycles.
- **rst_n asserted mid-burst:** all outputs take reset values immediately; after release, the first new write of 0x33 is output first.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared defaults for the UART byte-queue blocks.
//   ADDR_WIDTH : BRAM address width of the receive queue
//   DATA_WIDTH : byte width
//   DEPTH      : number of BRAM entries, 1 << ADDR_WIDTH
package uart_pkg;

  localparam int unsigned ADDR_WIDTH = 9;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

endpackage

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
// Valid/ready byte queue built on an external single-port BRAM with a
// registered read. Owns the pointers, occupancy and port arbitration, and
// holds the head byte in an output register for the consumer.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_data/in_valid       : byte stream from the UART receiver
//   in_ready               : space available (depends on registered state only)
//   out_data/out_valid     : registered head byte
//   out_ready              : consumer takes out_data this cycle
//   flush                  : synchronous empty of the whole queue
//   clr_overflow, overflow : sticky dropped-write flag and its clear
//   level                  : bytes held (BRAM + in flight + output register)
//   mem_addr/mem_wd/mem_wen: BRAM port controls
//   mem_rd                 : BRAM read data, one cycle after mem_addr
module uart_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = uart_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic                  clr_overflow,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  // mem_count value meaning "every BRAM entry is occupied"
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic                  rd_pending;

  logic wr;
  logic rd_issue;
  logic drop;

  // Port arbitration. The receiver cannot stall, so a write always owns the
  // single BRAM port; a read is only issued in a cycle without a write and
  // only when the output register will be free by the time data returns.
  always_comb begin
    in_ready = (mem_count != FULL_COUNT);
    wr       = in_valid && in_ready && !flush;
    rd_issue = (mem_count != '0) && !rd_pending && (!out_valid || out_ready)
               && !wr && !flush;
    drop     = in_valid && !in_ready;

    mem_wen  = wr;
    mem_addr = wr ? wptr : rptr;
    mem_wd   = in_data;

    level    = mem_count
             + {{ADDR_WIDTH{1'b0}}, rd_pending}
             + {{ADDR_WIDTH{1'b0}}, out_valid};
  end

  // Pointers and occupancy. wr and rd_issue are exclusive, so mem_count
  // never moves in both directions in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (wr) begin
        wptr      <= wptr + 1'b1;
        mem_count <= mem_count + 1'b1;
      end else if (rd_issue) begin
        rptr      <= rptr + 1'b1;
        mem_count <= mem_count - 1'b1;
      end
      // rd_issue requires !rd_pending, so this also retires a capture
      rd_pending <= rd_issue;
    end
  end

  // Output register. A capture only happens when out_valid is already low
  // (or being popped at issue time), so capture and pop never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (rd_pending) begin
      out_data  <= mem_rd;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow; a new drop outranks a simultaneous clear. Flush leaves
  // the flag alone so software still sees that data was lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl
// Directed bench for uart_fifo_ctrl with a behavioural single-port,
// read-first, registered-read BRAM and an in-order byte scoreboard.
module tb_uart_fifo_ctrl;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned NDEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          clr_overflow;
  logic          overflow;
  logic [AW:0]   level;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_wen;
  logic [DW-1:0] mem_rd;

  logic [DW-1:0] bram [NDEPTH];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned acc_cnt = 0;
  int unsigned pop_cnt = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .clr_overflow(clr_overflow),
    .overflow(overflow), .level(level), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_wen(mem_wen), .mem_rd(mem_rd)
  );

  always @(posedge clk) begin
    if (mem_wen) bram[mem_addr] <= mem_wd;
    mem_rd <= bram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, score accepts and pops, then return
  // 2 time units after the edge with all inputs idle.
  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (iv && in_ready && !flush) begin
      exp_q.push_back(d);
      acc_cnt++;
    end
    if (out_valid && ordy) begin
      pop_cnt++;
      if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
      else check("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    #1;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < budget) begin
      tick(1'b0, '0, 1'b1);
      n++;
    end
    check("drain_done", {22'h0, level}, 0);
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_level", {22'h0, level}, 0);
    check("rst_in_ready", {31'h0, in_ready}, 1);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data", {24'h0, out_data}, 0);
    check("rst_overflow", {31'h0, overflow}, 0);
    check("rst_mem_wen", {31'h0, mem_wen}, 0);
    check("rst_mem_addr", {23'h0, mem_addr}, 0);

    // single write of 0xA5
    in_valid = 1'b1; in_data = 8'hA5; #1;
    check("w1_wen", {31'h0, mem_wen}, 1);
    check("w1_addr", {23'h0, mem_addr}, 0);
    check("w1_wd", {24'h0, mem_wd}, 8'hA5);
    tick(1'b1, 8'hA5, 1'b0);
    check("w1_c1_level", {22'h0, level}, 1);
    check("w1_c1_rd_addr", {23'h0, mem_addr}, 0);
    check("w1_c1_wen", {31'h0, mem_wen}, 0);
    check("w1_c1_in_ready", {31'h0, in_ready}, 1);
    tick(1'b0, '0, 1'b0);
    check("w1_c2_level", {22'h0, level}, 1);
    check("w1_c2_out_valid", {31'h0, out_valid}, 0);
    tick(1'b0, '0, 1'b0);
    check("w1_c3_out_valid", {31'h0, out_valid}, 1);
    check("w1_c3_out_data", {24'h0, out_data}, 8'hA5);
    check("w1_c3_level", {22'h0, level}, 1);
    tick(1'b0, '0, 1'b1);
    check("w1_pop_level", {22'h0, level}, 0);
    check("w1_pop_valid", {31'h0, out_valid}, 0);

    // burst of four back-to-back writes: port must stay on the write side
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); out_ready = 1'b1; #1;
      check("burst_wen", {31'h0, mem_wen}, 1);
      check("burst_addr", {23'h0, mem_addr}, 32'(i));
      tick(1'b1, 8'(i + 1), 1'b1);
    end
    drain(40);
    check("burst_rptr", {23'h0, mem_addr}, 4);
    in_valid = 1'b1; #1;
    check("burst_wptr", {23'h0, mem_addr}, 4);
    in_valid = 1'b0; #1;

    // fill to DEPTH+1, overflow set/clear behaviour, then drain in order
    do_reset();
    for (int i = 0; i < int'(NDEPTH); i++) tick(1'b1, 8'(i * 7 + 3), 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0);
    check("fill_level", {22'h0, level}, NDEPTH);
    check("fill_in_ready", {31'h0, in_ready}, 1);
    check("fill_head", {24'h0, out_data}, 8'h03);
    tick(1'b1, 8'hC3, 1'b0);
    check("full_level", {22'h0, level}, NDEPTH + 1);
    check("full_in_ready", {31'h0, in_ready}, 0);
    in_valid = 1'b1; in_data = 8'h99; #1;
    check("full_wen", {31'h0, mem_wen}, 0);
    tick(1'b1, 8'h99, 1'b0);
    check("ovf_set", {31'h0, overflow}, 1);
    check("ovf_level", {22'h0, level}, NDEPTH + 1);
    clr_overflow = 1'b1;
    tick(1'b0, '0, 1'b0);
    check("ovf_clr", {31'h0, overflow}, 0);
    clr_overflow = 1'b1;
    tick(1'b1, 8'h98, 1'b0);
    check("ovf_set_wins", {31'h0, overflow}, 1);
    clr_overflow = 1'b1;
    tick(1'b0, '0, 1'b0);
    check("ovf_clr2", {31'h0, overflow}, 0);
    drain(2000);

    // wrap-around: 600 writes with interleaved reads
    do_reset();
    acc_cnt = 0; pop_cnt = 0;
    for (int c = 0; c < 5000 && acc_cnt < 600; c++)
      tick(1'(c % 3 != 2), 8'(acc_cnt * 13 + 5), 1'(c % 5 != 0));
    check("wrap_accepts", acc_cnt, 600);
    drain(2000);
    check("wrap_pops", pop_cnt, 600);
    check("wrap_rptr", {23'h0, mem_addr}, 600 % NDEPTH);

    // flush with a read in flight and three bytes still in BRAM
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
    tick(1'b0, '0, 1'b0);
    check("pre_flush_level", {22'h0, level}, 4);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; #1;
    check("flush_wen", {31'h0, mem_wen}, 0);
    tick(1'b1, 8'hEE, 1'b0);
    check("flush_level", {22'h0, level}, 0);
    check("flush_out_valid", {31'h0, out_valid}, 0);
    exp_q.delete();
    repeat (3) tick(1'b0, '0, 1'b0);
    check("flush_no_stale", {31'h0, out_valid}, 0);
    in_valid = 1'b1; #1;
    check("flush_wptr", {23'h0, mem_addr}, 0);
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b0, '0, 1'b0);
    check("flush_5a_c2", {31'h0, out_valid}, 0);
    tick(1'b0, '0, 1'b0);
    check("flush_5a_valid", {31'h0, out_valid}, 1);
    check("flush_5a_data", {24'h0, out_data}, 8'h5A);
    drain(20);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h70 + i), 1'b0);
    in_valid = 1'b1; in_data = 8'h77;
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("mrst_level", {22'h0, level}, 0);
    check("mrst_out_valid", {31'h0, out_valid}, 0);
    check("mrst_out_data", {24'h0, out_data}, 0);
    check("mrst_in_ready", {31'h0, in_ready}, 1);
    check("mrst_mem_addr", {23'h0, mem_addr}, 0);
    check("mrst_mem_wen", {31'h0, mem_wen}, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    tick(1'b1, 8'h33, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    check("mrst_first_valid", {31'h0, out_valid}, 1);
    check("mrst_first_data", {24'h0, out_data}, 8'h33);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
